// File: rtl/cr_fifo_pf_pkg.sv
// Package: cr_fifo_pf_pkg
// Shared types and helpers for the cr_fifo read-side prefetcher
// (cr_fifo_rd_prefetch and its ring buffer cr_fifo_pf_buf).
package cr_fifo_pf_pkg;

    localparam int unsigned PF_DATA_W = 71;

    typedef struct packed {
        logic [PF_DATA_W-1:0] data;
        logic                 err;
    } pf_entry_t;

    // Number of bits needed to hold the values 0..n inclusive.
    function automatic int unsigned clog2_cnt(input int unsigned n);
        int unsigned bits;
        bits = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) <= 64'(n)) begin
                bits = i + 1;
            end
        end
        return bits;
    endfunction

endpackage

// File: rtl/cr_fifo_pf_buf.sv
// Module: cr_fifo_pf_buf
// Flop-based DEPTH-entry ring holding prefetched read words. The head entry
// is presented straight from its storage flops, so rentry is registered.
module cr_fifo_pf_buf
    import cr_fifo_pf_pkg::*;
#(
    parameter int unsigned ENTRY_W = PF_DATA_W,
    parameter int unsigned DEPTH   = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clear,
    input  logic                          push,
    input  logic                          pop,
    input  logic [ENTRY_W-1:0]            wentry,
    output logic [ENTRY_W-1:0]            rentry,
    output logic [clog2_cnt(DEPTH)-1:0]   count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = clog2_cnt(DEPTH);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic               do_push;
    logic               do_pop;

    // Pointer increment modulo DEPTH (DEPTH need not be a power of two).
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_push = push & ~clear;
    assign do_pop  = pop & ~clear & (count != '0);
    assign rentry  = mem[head];

    // Entry storage: written at the tail on every accepted push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push) begin
            mem[tail] <= wentry;
        end
    end

    // Head/tail pointers and occupancy; clear empties the ring in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                tail <= ptr_inc(tail);
            end
            if (do_pop) begin
                head <= ptr_inc(head);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Push into a full ring without a same-cycle pop would overwrite the head.
    assert property (@(posedge clk) disable iff (!rst_n)
        !(do_push && !do_pop && (count == CNT_W'(DEPTH))));

    // Pop is only ever requested while the head is valid.
    assert property (@(posedge clk) disable iff (!rst_n)
        !(pop && !clear && (count == '0)));

endmodule

// File: rtl/cr_fifo_rd_prefetch.sv
// Module: cr_fifo_rd_prefetch
// Read-side prefetcher for the cr_fifo_wrap2 read port. Issues fifo_ren ahead
// of demand using a credit count (buffered + in-flight words), tracks issued
// reads through an RD_LAT-deep pipe and captures returning words into a
// PF_DEPTH-entry ring that drives a valid/ready output stream.
// Optional feature: define CR_FIFO_PF_ERR_EN to store fifo_ecc_err per entry
// and present it on out_err; otherwise out_err is tied 0.
module cr_fifo_rd_prefetch
    import cr_fifo_pf_pkg::*;
#(
    parameter int unsigned DATA_W   = PF_DATA_W,
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned PF_DEPTH = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            clear,
    input  logic                            fifo_empty,
    output logic                            fifo_ren,
    input  logic [DATA_W-1:0]               fifo_rdata,
    input  logic                            fifo_ecc_err,
    output logic                            out_valid,
    output logic [DATA_W-1:0]               out_data,
    input  logic                            out_ready,
    output logic                            out_err,
    output logic [clog2_cnt(PF_DEPTH)-1:0]  pf_count
);

    generate
        if ((RD_LAT < 1) || (RD_LAT > 3)) begin : g_bad_rd_lat
            $error("cr_fifo_rd_prefetch: RD_LAT must be in 1..3");
        end
        if (PF_DEPTH < RD_LAT + 1) begin : g_bad_pf_depth
            $error("cr_fifo_rd_prefetch: PF_DEPTH must be >= RD_LAT+1");
        end
    endgenerate

    localparam int unsigned CRED_W = clog2_cnt(PF_DEPTH + RD_LAT) + 1;

`ifdef CR_FIFO_PF_ERR_EN
    localparam int unsigned ENTRY_W = DATA_W + 1;
`else
    localparam int unsigned ENTRY_W = DATA_W;
`endif

    logic [RD_LAT-1:0]  rd_pipe;
    logic [CRED_W-1:0]  inflight;
    logic [CRED_W-1:0]  credit_used;
    logic [CRED_W-1:0]  credit_cap;
    logic               pop;
    logic               push;
    logic [ENTRY_W-1:0] wentry;
    logic [ENTRY_W-1:0] rentry;

`ifdef CR_FIFO_PF_ERR_EN
    assign wentry   = {fifo_rdata, fifo_ecc_err};
    assign out_data = rentry[ENTRY_W-1:1];
    assign out_err  = rentry[0];
`else
    logic unused_ecc_err;
    assign unused_ecc_err = fifo_ecc_err;
    assign wentry         = fifo_rdata;
    assign out_data       = rentry;
    assign out_err        = 1'b0;
`endif

    // Count reads issued but not yet returned.
    always_comb begin
        inflight = '0;
        for (int unsigned i = 0; i < RD_LAT; i++) begin
            inflight = inflight + CRED_W'(rd_pipe[i]);
        end
    end

    assign pop       = out_valid & out_ready;
    assign out_valid = (pf_count != '0);

    // (pf_count + inflight - pop) < PF_DEPTH, with pop moved to the right-hand
    // side so the unsigned sum can never wrap below zero.
    assign credit_used = CRED_W'(pf_count) + inflight;
    assign credit_cap  = CRED_W'(PF_DEPTH) + CRED_W'(pop);
    assign fifo_ren    = rst_n & ~fifo_empty & ~clear & (credit_used < credit_cap);

    // Shift pipe of issued reads; the tail marks fifo_rdata valid this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pipe <= '0;
        end else if (clear) begin
            rd_pipe <= '0;
        end else begin
            rd_pipe[0] <= fifo_ren;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                rd_pipe[i] <= rd_pipe[i-1];
            end
        end
    end

    assign push = rd_pipe[RD_LAT-1];

    cr_fifo_pf_buf #(
        .ENTRY_W (ENTRY_W),
        .DEPTH   (PF_DEPTH)
    ) u_buf (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (clear),
        .push   (push),
        .pop    (pop),
        .wentry (wentry),
        .rentry (rentry),
        .count  (pf_count)
    );

endmodule

// File: tb/tb_cr_fifo_rd_prefetch.sv
// Testbench: tb_cr_fifo_rd_prefetch
// Directed bench with an upstream FIFO model and an output scoreboard.
module tb_cr_fifo_rd_prefetch;
    import cr_fifo_pf_pkg::*;

    localparam int unsigned DATA_W   = PF_DATA_W;
    localparam int unsigned RD_LAT   = 1;
    localparam int unsigned PF_DEPTH = 2;
    localparam int unsigned CNT_W    = clog2_cnt(PF_DEPTH);

    typedef logic [DATA_W:0] wide_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              clear;
    logic              fifo_empty;
    logic              fifo_ren;
    logic [DATA_W-1:0] fifo_rdata;
    logic              fifo_ecc_err;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic              out_err;
    logic [CNT_W-1:0]  pf_count;

    int          checks   = 0;
    int          failures = 0;
    int unsigned delivered  = 0;
    int unsigned ren_pulses = 0;
    int unsigned wptr = 0;
    int unsigned rptr = 0;

    pf_entry_t exp_q[$];
    pf_entry_t fmem [64];
    pf_entry_t rd_pipe [RD_LAT];
    pf_entry_t mon_e;
    logic      mon_err;

    always #5 clk = ~clk;

    cr_fifo_rd_prefetch #(
        .DATA_W   (DATA_W),
        .RD_LAT   (RD_LAT),
        .PF_DEPTH (PF_DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (clear),
        .fifo_empty   (fifo_empty),
        .fifo_ren     (fifo_ren),
        .fifo_rdata   (fifo_rdata),
        .fifo_ecc_err (fifo_ecc_err),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_ready    (out_ready),
        .out_err      (out_err),
        .pf_count     (pf_count)
    );

    // Upstream FIFO model: registered empty, data RD_LAT cycles after ren,
    // all-ones junk on the data bus whenever no read was issued.
    assign fifo_empty   = (wptr == rptr);
    assign fifo_rdata   = rd_pipe[RD_LAT-1].data;
    assign fifo_ecc_err = rd_pipe[RD_LAT-1].err;

    always @(posedge clk) begin
        if (fifo_ren) begin
            rptr       <= rptr + 1;
            ren_pulses <= ren_pulses + 1;
            rd_pipe[0] <= fmem[rptr % 64];
        end else begin
            rd_pipe[0] <= '1;
        end
        for (int i = 1; i < RD_LAT; i++) begin
            rd_pipe[i] <= rd_pipe[i-1];
        end
    end

    function automatic logic [DATA_W-1:0] mkword(input int unsigned i);
        logic [DATA_W-1:0] w;
        w              = '0;
        w[31:0]        = 32'hC0DE_0000 + i;
        w[63:32]       = i * 32'h9E37_79B9;
        w[DATA_W-1:64] = (DATA_W-64)'(i);
        return w;
    endfunction

    task automatic push_word(input int unsigned i, input logic err);
        pf_entry_t e;
        e.data = mkword(i);
        e.err  = err;
        fmem[wptr % 64] = e;
        exp_q.push_back(e);
        wptr = wptr + 1;
    endtask

    task automatic chk(input string tag, input wide_t obs, input wide_t exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Output monitor: protocol check every cycle, scoreboard pop on handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            assert ((fifo_ren && fifo_empty) === 1'b0) else begin
                failures++;
                $error("FAIL ren_while_empty observed=1 expected=0");
            end
            if (out_valid && out_ready) begin
                checks++;
                assert (exp_q.size() > 0) else begin
                    failures++;
                    $error("FAIL unexpected_word observed=%h expected=none", out_data);
                end
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
`ifdef CR_FIFO_PF_ERR_EN
                    mon_err = mon_e.err;
`else
                    mon_err = 1'b0;
`endif
                    checks += 2;
                    assert (out_data === mon_e.data) else begin
                        failures++;
                        $error("FAIL out_data observed=%h expected=%h", out_data, mon_e.data);
                    end
                    assert (out_err === mon_err) else begin
                        failures++;
                        $error("FAIL out_err observed=%b expected=%b", out_err, mon_err);
                    end
                end
                delivered++;
            end
        end
    end

    initial begin
        int unsigned base;
        int unsigned drop;

        // Reset, with one word already waiting upstream.
        rst_n     = 1'b0;
        clear     = 1'b0;
        out_ready = 1'b1;
        push_word(0, 1'b0);
        repeat (2) tick();
        chk("rst_fifo_ren",  wide_t'(fifo_ren),  wide_t'(1'b0));
        chk("rst_out_valid", wide_t'(out_valid), wide_t'(1'b0));
        chk("rst_out_data",  wide_t'(out_data),  wide_t'(0));
        chk("rst_out_err",   wide_t'(out_err),   wide_t'(1'b0));
        chk("rst_pf_count",  wide_t'(pf_count),  wide_t'(0));

        // Single word: exactly one read, delivered and nothing more.
        base  = ren_pulses;
        rst_n = 1'b1;
        repeat (5) tick();
        chk("one_word_ren",   wide_t'(ren_pulses - base), wide_t'(1));
        chk("one_word_valid", wide_t'(out_valid),         wide_t'(1'b0));
        chk("one_word_drain", wide_t'(exp_q.size()),      wide_t'(0));

        // Five words A..E streaming with out_ready=1; B carries an ECC flag.
        base = ren_pulses;
        for (int unsigned i = 1; i <= 5; i++) begin
            push_word(i, (i == 2));
        end
        tick();
        chk("lat_valid_c1", wide_t'(out_valid), wide_t'(1'b0));
        tick();
        chk("lat_valid_c2", wide_t'(out_valid), wide_t'(1'b1));
        chk("lat_first_A",  wide_t'(out_data),  wide_t'(mkword(1)));
        for (int unsigned k = 3; k <= 5; k++) begin
            tick();
            chk("stream_valid", wide_t'(out_valid), wide_t'(1'b1));
            chk("coincide_cnt", wide_t'(pf_count),  wide_t'(1));
        end
        tick();
        chk("stream_valid_E", wide_t'(out_valid), wide_t'(1'b1));
        tick();
        chk("stream_done",    wide_t'(out_valid),         wide_t'(1'b0));
        chk("stream_ren_cnt", wide_t'(ren_pulses - base), wide_t'(5));

        // Backpressure: ten words, consumer stalled, then released.
        out_ready = 1'b0;
        base      = ren_pulses;
        for (int unsigned i = 10; i < 20; i++) begin
            push_word(i, 1'b0);
        end
        repeat (6) tick();
        chk("stall_ren_cnt",  wide_t'(ren_pulses - base), wide_t'(PF_DEPTH));
        chk("stall_pf_count", wide_t'(pf_count),          wide_t'(PF_DEPTH));
        chk("stall_valid",    wide_t'(out_valid),         wide_t'(1'b1));
        chk("stall_head",     wide_t'(out_data),          wide_t'(exp_q[0].data));
        out_ready = 1'b1;
        for (int unsigned k = 0; k < 9; k++) begin
            tick();
            chk("release_no_gap", wide_t'(out_valid), wide_t'(1'b1));
        end
        tick();
        chk("release_done",  wide_t'(out_valid),         wide_t'(1'b0));
        chk("release_drain", wide_t'(exp_q.size()),      wide_t'(0));
        chk("release_ren",   wide_t'(ren_pulses - base), wide_t'(10));

        // Clear with one word buffered and one still in flight.
        out_ready = 1'b0;
        base      = ren_pulses;
        for (int unsigned i = 30; i < 40; i++) begin
            push_word(i, 1'b0);
        end
        tick();
        chk("pre_clr_cnt0", wide_t'(pf_count), wide_t'(0));
        tick();
        chk("pre_clr_cnt1",  wide_t'(pf_count),          wide_t'(1));
        chk("pre_clr_issued", wide_t'(ren_pulses - base), wide_t'(2));
        clear = 1'b1;
        #1;
        chk("clr_ren_forced", wide_t'(fifo_ren), wide_t'(1'b0));
        tick();
        clear = 1'b0;
        chk("post_clr_cnt",   wide_t'(pf_count),  wide_t'(0));
        chk("post_clr_valid", wide_t'(out_valid), wide_t'(1'b0));
        drop = ren_pulses - delivered;
        chk("clr_dropped", wide_t'(drop), wide_t'(2));
        for (int unsigned k = 0; k < drop; k++) begin
            void'(exp_q.pop_front());
        end
        out_ready = 1'b1;
        repeat (14) tick();
        chk("after_clr_done",  wide_t'(out_valid),         wide_t'(1'b0));
        chk("after_clr_drain", wide_t'(exp_q.size()),      wide_t'(0));
        chk("after_clr_ren",   wide_t'(ren_pulses - base), wide_t'(10));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
